// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI responder.
package spi_pkg;

   localparam int unsigned FRAME_W_DEFAULT = 60;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

   // Bit counter width: must hold the value FRAME_W without wrapping.
   function automatic int unsigned cnt_w(input int unsigned frame_w);
      return $clog2(frame_w + 1);
   endfunction

endpackage

// File: rtl/spi_tx_buf.sv
// Single-entry holding register for the next response word (valid/ready load, consume on frame start).
module spi_tx_buf
   import spi_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FRAME_W-1:0] tx_data,
   input  logic               tx_valid,
   input  logic               consume,
   output logic               tx_ready,
   output logic               buf_full,
   output logic [FRAME_W-1:0] tx_buf
);

   assign tx_ready = ~buf_full;

   // A load can only happen while empty, so it never collides with a consume of valid data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full <= 1'b0;
         tx_buf   <= '0;
      end else if (tx_valid && tx_ready) begin
         buf_full <= 1'b1;
         tx_buf   <= tx_data;
      end else if (consume) begin
         buf_full <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_slave_xcvr.sv
// SPI responder: captures an MSB-first frame from SPI_SDI and returns a preloaded word on SPI_SDO.
module spi_slave_xcvr
   import spi_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
   parameter logic        FILL    = 1'b0
) (
   input  logic               SPI_CLK,
   input  logic               reset,
   input  logic               CSB,
   input  logic               SPI_SDI,
   output logic               SPI_SDO,
   input  logic [FRAME_W-1:0] tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               frame_err,
   output logic               underrun
);

   localparam int unsigned CNT_W = cnt_w(FRAME_W);

   spi_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
   logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
   logic [FRAME_W-1:0] rx_data_d;
   logic               rx_valid_d, frame_err_d, underrun_d;
   logic               armed_q, armed_d;
   logic               consume_c;
   logic               buf_full;
   logic [FRAME_W-1:0] tx_buf;

   spi_tx_buf #(.FRAME_W(FRAME_W)) u_tx_buf (
      .clk      (SPI_CLK),
      .rst_n    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .consume  (consume_c),
      .tx_ready (tx_ready),
      .buf_full (buf_full),
      .tx_buf   (tx_buf)
   );

   // State and datapath registers.
   always_ff @(posedge SPI_CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rx_sr_q   <= '0;
         tx_sr_q   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_sr_q   <= rx_sr_d;
         tx_sr_q   <= tx_sr_d;
         rx_data   <= rx_data_d;
         rx_valid  <= rx_valid_d;
         frame_err <= frame_err_d;
         underrun  <= underrun_d;
         armed_q   <= armed_d;
      end
   end

   // Next-state and datapath updates; armed_q keeps a frame from starting until CSB has been seen high after reset.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      rx_data_d   = rx_data;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;
      consume_c   = 1'b0;
      armed_d     = armed_q | CSB;

      case (state_q)
         IDLE: begin
            if (armed_q && !CSB) begin
               rx_sr_d    = FRAME_W'(SPI_SDI);
               cnt_d      = CNT_W'(1);
               tx_sr_d    = buf_full ? {tx_buf[FRAME_W-2:0], FILL} : {FRAME_W{FILL}};
               consume_c  = 1'b1;
               underrun_d = ~buf_full;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (CSB) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               rx_sr_d = {rx_sr_q[FRAME_W-2:0], SPI_SDI};
               tx_sr_d = {tx_sr_q[FRAME_W-2:0], FILL};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                  rx_data_d  = {rx_sr_q[FRAME_W-2:0], SPI_SDI};
                  rx_valid_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            if (CSB) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SDO leads the sampling edge: the first bit comes straight from the holding buffer while still IDLE.
   always_comb begin
      SPI_SDO = FILL;
      if (!CSB) begin
         case (state_q)
            IDLE:    SPI_SDO = (armed_q && buf_full) ? tx_buf[FRAME_W-1] : FILL;
            SHIFT:   SPI_SDO = tx_sr_q[FRAME_W-1];
            default: SPI_SDO = FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Directed plus randomized frames against a word-level model of the SPI responder.
module tb_spi_slave_xcvr;
   localparam int unsigned FW = 60;

   logic          spi_clk = 1'b0;
   logic          reset   = 1'b0;
   logic          csb     = 1'b1;
   logic          spi_sdi = 1'b0;
   logic          spi_sdo;
   logic [FW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [FW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          underrun;

   int checks = 0;
   int errors = 0;

   // Word-level model: holding buffer contents and last good received frame.
   logic          exp_full = 1'b0;
   logic [FW-1:0] exp_buf  = '0;
   logic [FW-1:0] exp_rx   = '0;

   spi_slave_xcvr #(.FRAME_W(FW), .FILL(1'b0)) dut (
      .SPI_CLK   (spi_clk),
      .reset     (reset),
      .CSB       (csb),
      .SPI_SDI   (spi_sdi),
      .SPI_SDO   (spi_sdo),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .underrun  (underrun)
   );

   always #5 spi_clk = ~spi_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] rand_word();
      return FW'({$urandom(), $urandom()});
   endfunction

   task automatic load_word(input logic [FW-1:0] w);
      @(negedge spi_clk);
      chk("tx_ready_before_load", 64'(tx_ready), 64'(!exp_full));
      tx_valid = 1'b1;
      tx_data  = w;
      @(posedge spi_clk);
      #1;
      tx_valid = 1'b0;
      if (!exp_full) begin
         exp_full = 1'b1;
         exp_buf  = w;
      end
      chk("tx_ready_after_load", 64'(tx_ready), 64'd0);
   endtask

   // Master drives nbits clocks with CSB low, then one CSB-high edge; pulses are tallied per edge.
   task automatic send_frame(input logic [FW-1:0] w, input int nbits,
                             output logic [FW-1:0] cap, output int n_rxv, output int rxv_edge,
                             output int n_ferr, output int n_und, output int und_edge,
                             output int n_fill_bad, output int n_both);
      cap = '0; n_rxv = 0; rxv_edge = -1; n_ferr = 0; n_und = 0; und_edge = -1;
      n_fill_bad = 0; n_both = 0;
      for (int i = 0; i <= nbits; i++) begin
         @(negedge spi_clk);
         if (i < nbits) begin
            csb     = 1'b0;
            spi_sdi = (i < int'(FW)) ? w[FW-1-i] : 1'($urandom());
         end else begin
            csb     = 1'b1;
            spi_sdi = 1'b0;
         end
         #1;
         if (i < int'(FW) && i < nbits) cap[FW-1-i] = spi_sdo;
         else if (spi_sdo !== 1'b0) n_fill_bad++;
         @(posedge spi_clk);
         #1;
         if (rx_valid)  begin n_rxv++; rxv_edge = i + 1; end
         if (frame_err) n_ferr++;
         if (underrun)  begin n_und++; und_edge = i + 1; end
         if (rx_valid && frame_err) n_both++;
      end
   endtask

   task automatic frame_check(input string tag, input logic [FW-1:0] w, input int nbits);
      logic [FW-1:0] cap, exp_sdo;
      int n_rxv, rxv_edge, n_ferr, n_und, und_edge, n_fill_bad, n_both;
      logic exp_und;
      exp_sdo  = exp_full ? exp_buf : '0;
      exp_und  = !exp_full;
      exp_full = 1'b0;
      send_frame(w, nbits, cap, n_rxv, rxv_edge, n_ferr, n_und, und_edge, n_fill_bad, n_both);
      if (nbits >= int'(FW)) exp_rx = w;
      chk({tag, "_rx_data"}, 64'(rx_data), 64'(exp_rx));
      chk({tag, "_rx_valid_count"}, 64'(n_rxv), (nbits >= int'(FW)) ? 64'd1 : 64'd0);
      chk({tag, "_frame_err_count"}, 64'(n_ferr), (nbits < int'(FW)) ? 64'd1 : 64'd0);
      chk({tag, "_underrun_count"}, 64'(n_und), 64'(exp_und));
      chk({tag, "_pulse_overlap"}, 64'(n_both), 64'd0);
      chk({tag, "_sdo_fill"}, 64'(n_fill_bad), 64'd0);
      if (nbits >= int'(FW)) begin
         chk({tag, "_rx_valid_edge"}, 64'(rxv_edge), 64'(FW));
         chk({tag, "_sdo_word"}, 64'(cap), 64'(exp_sdo));
      end
      if (exp_und) chk({tag, "_underrun_edge"}, 64'(und_edge), 64'd1);
   endtask

   initial begin
      logic [FW-1:0] w;
      int nb, pulses;

      // Reset state
      repeat (2) @(posedge spi_clk);
      #1;
      chk("reset_rx_data", 64'(rx_data), 64'd0);
      chk("reset_rx_valid", 64'(rx_valid), 64'd0);
      chk("reset_frame_err", 64'(frame_err), 64'd0);
      chk("reset_underrun", 64'(underrun), 64'd0);
      chk("reset_tx_ready", 64'(tx_ready), 64'd1);
      chk("reset_sdo", 64'(spi_sdo), 64'd0);
      @(negedge spi_clk);
      reset = 1'b1;
      @(posedge spi_clk);

      load_word(60'h0F0F0F0F0F0F0F0);
      frame_check("basic", 60'hABCDEF012345678, 60);

      frame_check("underrun", rand_word(), 60);

      load_word(rand_word());
      frame_check("trunc30", rand_word(), 30);
      frame_check("after_trunc", 60'h1, 60);

      load_word(rand_word());
      frame_check("long65", rand_word(), 65);

      // Reset in the middle of a frame, released while CSB is still low
      for (int i = 0; i < 20; i++) begin
         @(negedge spi_clk);
         csb     = 1'b0;
         spi_sdi = 1'($urandom());
      end
      @(negedge spi_clk);
      reset = 1'b0;
      #1;
      chk("midrst_rx_data", 64'(rx_data), 64'd0);
      chk("midrst_rx_valid", 64'(rx_valid), 64'd0);
      chk("midrst_frame_err", 64'(frame_err), 64'd0);
      chk("midrst_underrun", 64'(underrun), 64'd0);
      chk("midrst_tx_ready", 64'(tx_ready), 64'd1);
      chk("midrst_sdo", 64'(spi_sdo), 64'd0);
      repeat (2) @(posedge spi_clk);
      @(negedge spi_clk);
      reset = 1'b1;
      pulses = 0;
      repeat (3) begin
         @(posedge spi_clk);
         #1;
         pulses += int'(rx_valid) + int'(frame_err) + int'(underrun);
      end
      chk("post_release_quiet", 64'(pulses), 64'd0);
      @(negedge spi_clk);
      csb = 1'b1;
      exp_full = 1'b0;
      exp_rx   = '0;
      frame_check("post_reset", 60'hFFFFFFFFFFFFFFF, 60);

      // tx_valid held across two frames
      @(negedge spi_clk);
      tx_valid = 1'b1;
      tx_data  = 60'h111111111111111;
      @(posedge spi_clk);
      #1;
      chk("hold_ready_after_first", 64'(tx_ready), 64'd0);
      exp_full = 1'b1;
      exp_buf  = 60'h111111111111111;
      tx_data  = 60'h222222222222222;
      frame_check("hold_frame1", rand_word(), 60);
      tx_valid = 1'b0;
      exp_full = 1'b1;
      exp_buf  = 60'h222222222222222;
      chk("hold_ready_after_second", 64'(tx_ready), 64'd0);
      frame_check("hold_frame2", rand_word(), 60);

      // Randomized frames
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 1) == 1) load_word(rand_word());
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 59))
                                          : 60 + int'($urandom_range(0, 3));
         w = rand_word();
         frame_check($sformatf("rand%0d", k), w, nb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
